axi_lite_cmd_sequencer: RTL and testbench
=========================================

// Module: axi_lite_cmd_sequencer
// PURPOSE
//  AXI-Lite master that runs a stream of write/read-check commands against the banzAI AXI-Lite slave.
//  Accepts one command at a time on a valid/ready port, performs the single AXI-Lite transaction,
//    masked-compares read data, and returns one response per command.
//  Replaces software-driven register bring-up; sits between the command FIFO/boot ROM and axi_port.
// PARAMETERS
//  ADDR_WIDTH      32    AXI address width
//  DATA_WIDTH      32    AXI data width; also cmd/rsp data and mask width
//  TIMEOUT_CYCLES  1024  max cycles in any wait state before abort; >=2
// PORTS
//  clk           in   1     clock, all logic on rising edge
//  rst_n         in   1     asynchronous reset, active-low
//  cmd_valid     in   1     command present
//  cmd_ready     out  1     command accepted when valid&ready
//  cmd_write     in   1     1=write, 0=read
//  cmd_addr      in   ADDR  target address
//  cmd_data      in   DATA  write data / expected read data
//  cmd_mask      in   DATA  read compare mask, 1=bit checked; ignored on writes
//  rsp_valid     out  1     response present
//  rsp_ready     in   1     response consumed when valid&ready
//  rsp_data      out  DATA  read data (reads), 0 (writes)
//  rsp_resp      out  2     b_resp / r_resp, or 2'b10 on timeout
//  rsp_mismatch  out  1     read: ((r_data^cmd_data)&cmd_mask)!=0; writes: 0
//  rsp_timeout   out  1     transaction aborted by timeout
//  mismatch_cnt  out  16    saturating count of mismatching reads
//  busy          out  1     state != IDLE
//  aw_addr/aw_valid/aw_ready, w_data/w_valid/w_ready, b_resp/b_valid/b_ready,
//  ar_addr/ar_valid/ar_ready, r_data/r_resp/r_valid/r_ready: AXI-Lite master side, std directions/widths
// BEHAVIOUR
//  Reset: state IDLE; all *_valid, *_ready outputs 0 except cmd_ready=1; rsp_* 0; mismatch_cnt 0.
//  Reset mid-transaction: immediate abort, no response produced, counter cleared.
//  States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, REPORT.
//  IDLE: cmd_ready=1; on handshake latch cmd_* -> WR_REQ or RD_REQ; valids rise next cycle.
//  WR_REQ: aw_valid, w_valid asserted together; each drops the cycle after its own handshake
//    (aw_done/w_done flags; same-cycle handshakes allowed). Both done -> WR_RESP.
//  WR_RESP: b_ready=1; on b_valid capture b_resp -> REPORT.
//  RD_REQ: ar_valid=1 until ar_ready -> RD_DATA. RD_DATA: r_ready=1; on r_valid capture r_data,
//    r_resp, mismatch -> REPORT; mismatch_cnt += mismatch, holds at 16'hFFFF.
//  Addr/data outputs stable from valid rise to handshake; no combinational ready->valid path.
//  Min latency: cmd handshake to rsp_valid = 3 cycles (write or read, slave ready-high).
//  REPORT: rsp_valid=1, rsp_* stable until rsp_ready; then IDLE. cmd_ready=0 in REPORT,
//    so at most one command in flight; no back-to-back cmd in the rsp handshake cycle.
//  Timeout: cycle counter cleared on entering each wait state; reaching TIMEOUT_CYCLES ->
//    drop all AXI valid/ready, REPORT with rsp_timeout=1, rsp_resp=2'b10, rsp_mismatch=0.
//    Abort breaks AXI rules; slave must be reset before next command (documented, not checked).
//  Non-OKAY b_resp/r_resp passed through; mismatch still evaluated on read data.
// STRUCTURE
//  banzai_axi_pkg: axi_resp_e (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11), seq_state_e enum.
//  Single module, no sub-modules; timeout counter and compare inline.
// TESTING
//  Write 0x10<=0xDEADBEEF, slave ready-high -> aw/w same cycle, rsp at +3, resp=00, mismatch=0.
//  Read 0x10 exp 0xDEADBEEF mask 0xFFFFFFFF -> rsp_data=0xDEADBEEF, mismatch=0, cnt=0.
//  Read exp 0xDEADBEEF, slave returns 0xDEADBEEE, mask 0xFFFFFFFE -> mismatch=0; mask all-1 -> 1, cnt=1.
//  Write with w_ready 5 cycles after aw_ready -> aw_valid low after its handshake, w held, one rsp.
//  ar_ready never asserted, TIMEOUT_CYCLES=16 -> rsp_timeout=1, resp=10, ar_valid low after 16.
//  rst_n low in RD_DATA, rsp_ready held low in REPORT -> outputs to reset values, no rsp; rsp held stable.

Source files
------------

// File: rtl/banzai_axi_pkg.sv
// banzai_axi_pkg: AXI-Lite response codes and command sequencer state encoding.
package banzai_axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        REPORT
    } seq_state_e;

endpackage

// File: rtl/axi_lite_cmd_sequencer.sv
// axi_lite_cmd_sequencer: runs one write or masked read-check command at a time
// as a single AXI-Lite transaction and returns one response per command.
module axi_lite_cmd_sequencer
    import banzai_axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [DATA_WIDTH-1:0] cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_mismatch,
    output logic                  rsp_timeout,
    output logic [15:0]           mismatch_cnt,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] aw_addr,
    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    input  logic [1:0]            b_resp,
    input  logic                  b_valid,
    output logic                  b_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_valid,
    output logic                  r_ready
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    seq_state_e            state, state_next;
    logic [TW-1:0]         tmo_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q, mask_q;
    logic                  aw_done, w_done;
    logic                  wait_st, step, abort, rd_mm;

    assign aw_addr = addr_q;
    assign ar_addr = addr_q;
    assign w_data  = data_q;
    assign rd_mm   = |((r_data ^ data_q) & mask_q);

    always_comb begin
        cmd_ready  = state == IDLE;
        busy       = state != IDLE;
        aw_valid   = state == WR_REQ && !aw_done;
        w_valid    = state == WR_REQ && !w_done;
        b_ready    = state == WR_RESP;
        ar_valid   = state == RD_REQ;
        r_ready    = state == RD_DATA;
        rsp_valid  = state == REPORT;
        wait_st    = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
        // step: the wait state's own completion event happens this cycle
        step       = (state == WR_REQ  && (aw_done || aw_ready) && (w_done || w_ready)) ||
                     (state == WR_RESP && b_valid) ||
                     (state == RD_REQ  && ar_ready) ||
                     (state == RD_DATA && r_valid);
        abort      = wait_st && !step && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
        state_next = state;
        case (state)
            IDLE:    state_next = cmd_valid ? (cmd_write ? WR_REQ : RD_REQ) : IDLE;
            WR_REQ:  state_next = step ? WR_RESP : (abort ? REPORT : WR_REQ);
            WR_RESP: state_next = (step || abort) ? REPORT : WR_RESP;
            RD_REQ:  state_next = step ? RD_DATA : (abort ? REPORT : RD_REQ);
            RD_DATA: state_next = (step || abort) ? REPORT : RD_DATA;
            REPORT:  state_next = rsp_ready ? IDLE : REPORT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            rsp_data     <= '0;
            rsp_resp     <= '0;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= (state_next != state) ? '0 : tmo_cnt + 1'b1;
            if (state == IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                data_q  <= cmd_data;
                mask_q  <= cmd_mask;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_valid && aw_ready)
                aw_done <= 1'b1;
            if (w_valid && w_ready)
                w_done <= 1'b1;
            // response fields are frozen on entry to REPORT and held until consumed
            if (state_next == REPORT && state != REPORT) begin
                rsp_data     <= (state == RD_DATA && !abort) ? r_data : '0;
                rsp_resp     <= abort ? SLVERR : (state == WR_RESP ? b_resp : r_resp);
                rsp_mismatch <= state == RD_DATA && !abort && rd_mm;
                rsp_timeout  <= abort;
            end
            if (state == RD_DATA && r_valid && rd_mm && mismatch_cnt != 16'hFFFF)
                mismatch_cnt <= mismatch_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_sequencer.sv
// tb_axi_lite_cmd_sequencer: directed and randomized command streams against a
// behavioural AXI-Lite slave and a memory-level reference model.
module tb_axi_lite_cmd_sequencer;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
    logic [31:0] cmd_addr = '0, cmd_data = '0, cmd_mask = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_mismatch, rsp_timeout, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [15:0] mismatch_cnt;
    logic [31:0] aw_addr, w_data, ar_addr, r_data = '0;
    logic        aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic        aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0, b_valid = 1'b0, r_valid = 1'b0;
    logic [1:0]  b_resp = '0, r_resp = '0;

    int total = 0, bad = 0;

    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  bresp_cfg = '0, rresp_cfg = '0;
    logic [31:0] r_xor = '0;

    bit          got_aw, got_w, got_ar, b_fire, r_fire;
    int          aw_age, w_age, ar_age, b_wait, r_wait;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [31:0] s_mem [logic [31:0]];

    logic [31:0] m_mem [logic [31:0]];
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    axi_lite_cmd_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_mismatch(rsp_mismatch), .rsp_timeout(rsp_timeout),
        .mismatch_cnt(mismatch_cnt), .busy(busy),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
    );

    // Slave: decides on each falling edge what it drives for the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
            got_aw = 0; got_w = 0; got_ar = 0; b_fire = 0; r_fire = 0;
            aw_age = 0; w_age = 0; ar_age = 0; b_wait = 0; r_wait = 0;
        end else begin
            if (b_fire) b_valid = 0;
            if (r_fire) r_valid = 0;
            if (got_aw && got_w && !b_valid) begin
                if (b_wait >= b_lat) begin
                    b_valid = 1; b_resp = bresp_cfg; s_mem[s_awaddr] = s_wdata;
                    got_aw = 0; got_w = 0; b_wait = 0;
                end else b_wait++;
            end
            if (got_ar && !r_valid) begin
                if (r_wait >= r_lat) begin
                    r_valid = 1; r_resp = rresp_cfg;
                    r_data = (s_mem.exists(s_araddr) ? s_mem[s_araddr] : 32'h0) ^ r_xor;
                    got_ar = 0; r_wait = 0;
                end else r_wait++;
            end
            b_fire = b_valid && b_ready;
            r_fire = r_valid && r_ready;
            aw_ready = aw_valid && !got_aw && aw_age >= aw_lat;
            if (aw_ready) begin got_aw = 1; s_awaddr = aw_addr; aw_age = 0; end
            else aw_age = aw_valid ? aw_age + 1 : 0;
            w_ready = w_valid && !got_w && w_age >= w_lat;
            if (w_ready) begin got_w = 1; s_wdata = w_data; w_age = 0; end
            else w_age = w_valid ? w_age + 1 : 0;
            ar_ready = ar_valid && !got_ar && ar_age >= ar_lat;
            if (ar_ready) begin got_ar = 1; s_araddr = ar_addr; ar_age = 0; end
            else ar_age = ar_valid ? ar_age + 1 : 0;
        end
    end

    task automatic issue_cmd(input logic w, input logic [31:0] a, d, m, output bit ok);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d; cmd_mask = m;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        ok = cmd_ready;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, want 1", cmd_ready, n);
        end else @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int n_aw, output int n_w, output int n_ar);
        lat = 0; n_aw = 0; n_w = 0; n_ar = 0;
        do begin
            @(negedge clk);
            lat++;
            if (aw_valid) n_aw++;
            if (w_valid) n_w++;
            if (ar_valid) n_ar++;
        end while (!rsp_valid && lat < 200);
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, want 1", rsp_valid, lat);
        end
    endtask

    task automatic ack_rsp(input int hold);
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({cmd_ready, busy, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 10000000",
                     {cmd_ready, busy, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid});
        end
        total++;
        if ({rsp_data, rsp_resp, rsp_mismatch, rsp_timeout, mismatch_cnt} !== 52'h0) begin
            bad++;
            $display("FAIL reset_rsp: data=%h resp=%b mm=%b to=%b cnt=%0d want all 0",
                     rsp_data, rsp_resp, rsp_mismatch, rsp_timeout, mismatch_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_basic;
        bit ok; int lat, na, nw, nr;
        issue_cmd(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, ok);
        wait_rsp(lat, na, nw, nr);
        m_mem[32'h10] = 32'hDEADBEEF;
        total++;
        if (lat != 3 || na != 1 || nw != 1) begin
            bad++;
            $display("FAIL wr_timing: lat=%0d aw=%0d w=%0d want 3/1/1", lat, na, nw);
        end
        total++;
        if ({rsp_data, rsp_resp, rsp_mismatch, rsp_timeout} !== {32'h0, 2'b00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL wr_rsp: data=%h resp=%b mm=%b to=%b want 0/00/0/0",
                     rsp_data, rsp_resp, rsp_mismatch, rsp_timeout);
        end
        total++;
        if (s_mem[32'h10] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_slave_mem: got %h want deadbeef", s_mem[32'h10]);
        end
        ack_rsp(0);
    endtask

    task automatic test_read_basic;
        bit ok; int lat, na, nw, nr;
        issue_cmd(1'b0, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, ok);
        wait_rsp(lat, na, nw, nr);
        total++;
        if (lat != 3 || nr != 1) begin
            bad++;
            $display("FAIL rd_timing: lat=%0d ar=%0d want 3/1", lat, nr);
        end
        total++;
        if ({rsp_data, rsp_resp, rsp_mismatch, rsp_timeout, mismatch_cnt} !==
            {32'hDEADBEEF, 2'b00, 1'b0, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL rd_rsp: data=%h resp=%b mm=%b to=%b cnt=%0d want deadbeef/00/0/0/0",
                     rsp_data, rsp_resp, rsp_mismatch, rsp_timeout, mismatch_cnt);
        end
        ack_rsp(0);
    endtask

    task automatic test_mask;
        bit ok; int lat, na, nw, nr;
        r_xor = 32'h1;
        issue_cmd(1'b0, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFE, ok);
        wait_rsp(lat, na, nw, nr);
        total++;
        if ({rsp_data, rsp_mismatch, mismatch_cnt} !== {32'hDEADBEEE, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL mask_ignored: data=%h mm=%b cnt=%0d want deadbeee/0/0", rsp_data, rsp_mismatch, mismatch_cnt);
        end
        ack_rsp(1);
        issue_cmd(1'b0, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, ok);
        wait_rsp(lat, na, nw, nr);
        exp_cnt = 1;
        total++;
        if ({rsp_data, rsp_mismatch, mismatch_cnt} !== {32'hDEADBEEE, 1'b1, 16'd1}) begin
            bad++;
            $display("FAIL mask_full: data=%h mm=%b cnt=%0d want deadbeee/1/1", rsp_data, rsp_mismatch, mismatch_cnt);
        end
        ack_rsp(0);
        r_xor = 32'h0;
    endtask

    task automatic test_write_skew;
        bit ok; int lat, na, nw, nr, extra = 0;
        w_lat = 5;
        issue_cmd(1'b1, 32'h14, 32'hA5A50F0F, 32'h0, ok);
        wait_rsp(lat, na, nw, nr);
        m_mem[32'h14] = 32'hA5A50F0F;
        total++;
        if (na != 1 || nw != 6) begin
            bad++;
            $display("FAIL skew_valids: aw_cycles=%0d w_cycles=%0d want 1/6", na, nw);
        end
        ack_rsp(0);
        repeat (4) begin @(negedge clk); if (rsp_valid) extra++; end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL skew_single_rsp: extra rsp cycles=%0d want 0", extra);
        end
        total++;
        if (s_mem[32'h14] !== 32'hA5A50F0F) begin
            bad++;
            $display("FAIL skew_slave_mem: got %h want a5a50f0f", s_mem[32'h14]);
        end
        w_lat = 0;
    endtask

    task automatic test_err_resp;
        bit ok; int lat, na, nw, nr;
        bresp_cfg = 2'b11;
        issue_cmd(1'b1, 32'h20, 32'h12345678, 32'h0, ok);
        wait_rsp(lat, na, nw, nr);
        m_mem[32'h20] = 32'h12345678;
        total++;
        if ({rsp_resp, rsp_mismatch} !== 3'b110) begin
            bad++;
            $display("FAIL err_bresp: resp=%b mm=%b want 11/0", rsp_resp, rsp_mismatch);
        end
        ack_rsp(0);
        rresp_cfg = 2'b01; r_xor = 32'h100;
        issue_cmd(1'b0, 32'h20, 32'h12345678, 32'hFFFFFFFF, ok);
        wait_rsp(lat, na, nw, nr);
        exp_cnt++;
        total++;
        if ({rsp_data, rsp_resp, rsp_mismatch, mismatch_cnt} !== {32'h12345778, 2'b01, 1'b1, 16'(exp_cnt)}) begin
            bad++;
            $display("FAIL err_rresp: data=%h resp=%b mm=%b cnt=%0d want 12345778/01/1/%0d",
                     rsp_data, rsp_resp, rsp_mismatch, mismatch_cnt, exp_cnt);
        end
        ack_rsp(0);
        bresp_cfg = 2'b00; rresp_cfg = 2'b00; r_xor = 32'h0;
    endtask

    task automatic test_timeout;
        bit ok; int lat, na, nw, nr;
        ar_lat = 1000;
        issue_cmd(1'b0, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, ok);
        wait_rsp(lat, na, nw, nr);
        total++;
        if (nr != 16 || ar_valid !== 1'b0) begin
            bad++;
            $display("FAIL tmo_ar: ar_cycles=%0d ar_valid=%b want 16/0", nr, ar_valid);
        end
        total++;
        if ({rsp_timeout, rsp_resp, rsp_mismatch, mismatch_cnt} !== {1'b1, 2'b10, 1'b0, 16'(exp_cnt)}) begin
            bad++;
            $display("FAIL tmo_rsp: to=%b resp=%b mm=%b cnt=%0d want 1/10/0/%0d",
                     rsp_timeout, rsp_resp, rsp_mismatch, mismatch_cnt, exp_cnt);
        end
        ack_rsp(0);
        ar_lat = 0;
    endtask

    task automatic test_hold;
        bit ok; int lat, na, nw, nr;
        issue_cmd(1'b0, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, ok);
        wait_rsp(lat, na, nw, nr);
        cmd_valid = 1'b1; cmd_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp_valid, cmd_ready, rsp_data, rsp_resp, rsp_mismatch, rsp_timeout} !==
                {1'b1, 1'b0, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_cycle%0d: valid=%b cmd_ready=%b data=%h resp=%b mm=%b to=%b want 1/0/deadbeef/00/0/0",
                         i, rsp_valid, cmd_ready, rsp_data, rsp_resp, rsp_mismatch, rsp_timeout);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        ack_rsp(0);
    endtask

    task automatic test_reset_mid;
        bit ok; int extra = 0;
        r_lat = 5;
        issue_cmd(1'b0, 32'h14, 32'h0, 32'hFFFFFFFF, ok);
        repeat (3) @(negedge clk);
        total++;
        if (r_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_in_rd_data: r_ready=%b want 1", r_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        total++;
        if ({cmd_ready, busy, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid} !== 8'b1000_0000 ||
            mismatch_cnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset: ctrl=%b cnt=%0d want 10000000/0",
                     {cmd_ready, busy, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid}, mismatch_cnt);
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        r_lat = 0;
        repeat (8) begin @(negedge clk); if (rsp_valid || busy) extra++; end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL mid_no_rsp: rsp/busy cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 40; i++) begin
            bit ok; int lat, na, nw, nr;
            logic w;
            logic [31:0] a, d, m, rv;
            logic [1:0] er;
            logic emm;
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 7)) << 2;
            m = $urandom_range(0, 1) ? 32'hFFFFFFFF : $urandom;
            d = ($urandom_range(0, 1) && m_mem.exists(a)) ? m_mem[a] : $urandom;
            aw_lat = $urandom_range(0, 4); w_lat = $urandom_range(0, 4); b_lat = $urandom_range(0, 4);
            ar_lat = $urandom_range(0, 4); r_lat = $urandom_range(0, 4);
            bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
            r_xor = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            rv  = (m_mem.exists(a) ? m_mem[a] : 32'h0) ^ r_xor;
            emm = !w && (((rv ^ d) & m) != 0);
            er  = w ? bresp_cfg : rresp_cfg;
            if (w) m_mem[a] = d;
            if (emm && exp_cnt < 65535) exp_cnt++;
            issue_cmd(w, a, d, m, ok);
            if (!ok) break;
            wait_rsp(lat, na, nw, nr);
            if (!rsp_valid) break;
            total++;
            if ({rsp_data, rsp_resp, rsp_mismatch, rsp_timeout} !== {(w ? 32'h0 : rv), er, emm, 1'b0}) begin
                bad++;
                $display("FAIL rand%0d_rsp: %s a=%h data=%h resp=%b mm=%b to=%b want %h/%b/%b/0",
                         i, w ? "wr" : "rd", a, rsp_data, rsp_resp, rsp_mismatch, rsp_timeout,
                         w ? 32'h0 : rv, er, emm);
            end
            total++;
            if (mismatch_cnt !== 16'(exp_cnt)) begin
                bad++;
                $display("FAIL rand%0d_cnt: cnt=%0d want %0d", i, mismatch_cnt, exp_cnt);
            end
            ack_rsp($urandom_range(0, 2));
        end
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00; r_xor = 32'h0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_write_basic;
        test_read_basic;
        test_mask;
        test_write_skew;
        test_err_resp;
        test_timeout;
        test_hold;
        test_reset_mid;
        test_back_to_back;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
